seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
//
// PURPOSE
// Time-multiplexing scan controller for the 4-digit 7-segment display.
// - Holds a 16-bit display value, four hex nibbles.
// - Presents one nibble per scan slot to the hex-to-7-segment decoder.
// - Drives the matching active-low digit enable; the decoder supplies the segment pattern.
// - Takes new values over a valid/ready handshake and commits them only at a frame boundary, so a frame never shows a mix of old and new values.
//
// PARAMETERS
// DIV        1000  clock cycles per scan tick (>=2)
// GAP_TICKS  1     blanking ticks inserted after each digit (0 = no gap)
//
// PORTS
// clk         in   1   system clock, rising edge
// rst         in   1   synchronous reset, active-high
// load_valid  in   1   new display value offered
// load_data   in   16  value; [3:0]=digit0 (rightmost) .. [15:12]=digit3
// load_ready  out  1   shadow register free; transfer when valid&&ready
// blank_mask  in   4   1 = keep digit k dark (sampled each cycle)
// nib         out  4   nibble of the current digit, to the decoder input
// an          out  4   digit enables, active-low, one-hot-zero or 1111
// frame_tick  out  1   1-cycle pulse when a frame completes and commit occurs
//
// BEHAVIOUR
// - Prescaler pcnt counts 0..DIV-1 and wraps. tick = (pcnt==DIV-1).
// - State = digit index d (0..3) + phase {SHOW, GAP}; gcnt counts GAP ticks.
// - FSM transitions advance only on tick:
//   - SHOW(d) -> GAP(d) if GAP_TICKS>0, else SHOW(d+1 mod 4).
//   - GAP(d) stays for GAP_TICKS ticks, then -> SHOW(d+1 mod 4).
// - Frame length = 4*DIV*(1+GAP_TICKS) cycles.
// - Frame end = the tick that leaves the last slot of d=3 (SHOW(3) if GAP_TICKS=0, else GAP(3)).
// - an, nib and frame_tick are registered, computed from the next state:
//   - SHOW(d): an = ~(1<<d), unless blank_mask[d]=1, then an = 1111.
//   - GAP: an = 1111.
//   - nib = disp[4d+3:4d] in every phase.
// - Handshake:
//   - load_ready = ~pending.
//   - When load_valid && load_ready: shadow <= load_data, pending <= 1.
//   - load_valid while !load_ready is ignored. The source must hold it.
// - Commit on the frame-end tick when pending=1: disp <= shadow, pending <= 0.
//   - New disp is visible from the first SHOW(0) of the next frame.
// - frame_tick pulses on every frame-end tick, whether or not a commit happened.
// - Simultaneous events:
//   - Commit and load in the same cycle cannot occur, because load_ready=0 while pending.
//   - load_ready rises the cycle after a commit.
//   - A load accepted in the frame-end cycle is committed at the following frame end.
// - Reset, any state, mid-frame included:
//   - pcnt=0, gcnt=0, d=0, phase=SHOW, disp=0, shadow=0, pending=0.
//   - Outputs: an=1111, nib=0, frame_tick=0, load_ready=1.
//   - First edge after rst deasserts: an=1110, nib=0.
// - No combinational path from inputs to outputs, except load_ready from the pending register.
//
// TESTING (DIV=4, GAP_TICKS=1, 32-cycle frame)
// 1. Release reset with blank_mask=0 -> an sequence 1110(4cy),1111(4),1101(4),1111(4),1011(4),1111(4),0111(4),1111(4) repeats; nib=0.
// 2. Load 16'hA3F1 at cycle 5 -> load_ready=0 next cycle; disp unchanged until frame end (cycle 32); frame_tick=1 there; next frame nib=1,F,3,A in SHOW(0..3); load_ready=1 at cycle 33.
// 3. Second load_valid 16'h1234 held while pending -> not accepted until load_ready=1; then committed one frame later; 16'hA3F1 frame shown in between.
// 4. blank_mask=4'b0101 -> an stays 1111 during SHOW(0) and SHOW(2); SHOW(1), SHOW(3) unaffected; nib still cycles.
// 5. Assert rst during SHOW(2) with pending=1 -> next cycle an=1111, load_ready=1, disp=0; pending value discarded; scan restarts at digit 0.
// 6. Rebuild with GAP_TICKS=0 -> an 1110,1101,1011,0111 (4cy each); frame_tick every 16 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: prescaled digit/gap sequencing with
// a one-entry shadow register that is committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned DIV       = 1000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [0:0] SHOW = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  logic [PW-1:0] pcnt, pcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [0:0]    phase, phase_n;
  logic [1:0]    d, d_n;
  logic [15:0]   disp, disp_n;
  logic [15:0]   shadow, shadow_n;
  logic          pending, pending_n;
  logic [3:0]    an_n, nib_n;
  logic          tick, frame_end, accept;

  assign load_ready = ~pending;

  // State register; outputs are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      gcnt       <= '0;
      phase      <= SHOW;
      d          <= 2'd0;
      disp       <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      an         <= 4'hF;
      nib        <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      gcnt       <= gcnt_n;
      phase      <= phase_n;
      d          <= d_n;
      disp       <= disp_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      an         <= an_n;
      nib        <= nib_n;
      frame_tick <= frame_end;
    end
  end

  // Next-state, handshake/commit and output decode.
  always_comb begin
    tick      = (pcnt == PLAST);
    pcnt_n    = tick ? '0 : pcnt + PW'(1);
    phase_n   = phase;
    d_n       = d;
    gcnt_n    = gcnt;
    frame_end = 1'b0;

    if (tick) begin
      if (phase == SHOW) begin
        if (GAP_TICKS > 0) begin
          phase_n = GAP;
          gcnt_n  = '0;
        end else begin
          d_n       = d + 2'd1;
          frame_end = (d == 2'd3);
        end
      end else if (gcnt == GLAST) begin
        phase_n   = SHOW;
        gcnt_n    = '0;
        d_n       = d + 2'd1;
        frame_end = (d == 2'd3);
      end else begin
        gcnt_n = gcnt + GW'(1);
      end
    end

    // Load and commit are mutually exclusive: a commit needs pending=1, a load needs pending=0.
    accept    = load_valid && !pending;
    shadow_n  = accept ? load_data : shadow;
    pending_n = pending;
    disp_n    = disp;
    if (accept) begin
      pending_n = 1'b1;
    end else if (frame_end && pending) begin
      disp_n    = shadow;
      pending_n = 1'b0;
    end

    if (phase_n == GAP || blank_mask[d_n]) begin
      an_n = 4'hF;
    end else begin
      an_n = ~(4'b0001 << d_n);
    end

    case (d_n)
      2'd0:    nib_n = disp_n[3:0];
      2'd1:    nib_n = disp_n[7:4];
      2'd2:    nib_n = disp_n[11:8];
      default: nib_n = disp_n[15:12];
    endcase
  end

endmodule
